// File: rtl/mxu_arbiter_pkg.sv
// Shared types and defaults for the matrix-unit job arbiter.
// Element (r,c) of a flat matrix sits at bit offset (r*DIM+c)*element_width.
package mxu_arbiter_pkg;

   localparam int MXU_DIM       = 4;
   localparam int MXU_WIDTH     = 8;
   localparam int MXU_OUT_WIDTH = 2 * MXU_WIDTH + $clog2(MXU_DIM);

   typedef logic [MXU_DIM*MXU_DIM*MXU_WIDTH-1:0]     matrix_in_t;
   typedef logic [MXU_DIM*MXU_DIM*MXU_OUT_WIDTH-1:0] matrix_out_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mxu_rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above the pointer,
// otherwise the lowest requester overall (the wrap-around case).
module mxu_rr_arbiter
   import mxu_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   logic [NUM_REQ-1:0] w_mask;
   logic [NUM_REQ-1:0] w_hi;
   logic [NUM_REQ-1:0] w_pick;

   // Requests at or above the pointer take priority; isolate the lowest set bit.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_mask[i] = (IDX_W'(i) >= i_ptr);
      end
      w_hi    = i_req & w_mask;
      w_pick  = (w_hi != '0) ? w_hi : i_req;
      o_grant = w_pick & (~w_pick + NUM_REQ'(1));
      o_any   = (i_req != '0);
   end

   // Encode the one-hot grant into an index.
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         o_idx = o_idx | (o_grant[i] ? IDX_W'(i) : IDX_W'(0));
      end
   end

endmodule

// File: rtl/mxu_arbiter.sv
// Shares one matrix multiplier among NUM_REQ requesters, one job in flight,
// with a watchdog that returns a zeroed, flagged result if the unit never finishes.
module mxu_arbiter
   import mxu_arbiter_pkg::*;
#(
   parameter int DIM       = MXU_DIM,
   parameter int WIDTH     = MXU_WIDTH,
   parameter int OUT_WIDTH = 2 * WIDTH + $clog2(DIM),
   parameter int NUM_REQ   = 4,
   parameter int TIME_MAX  = 1024
)(
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ*DIM*DIM*WIDTH-1:0]     req_a,
   input  logic [NUM_REQ*DIM*DIM*WIDTH-1:0]     req_b,
   output logic [DIM*DIM*WIDTH-1:0]             mxu_in0,
   output logic [DIM*DIM*WIDTH-1:0]             mxu_in1,
   output logic                                 mxu_in_valid,
   input  logic [DIM*DIM*OUT_WIDTH-1:0]         mxu_out,
   input  logic                                 mxu_finished,
   output logic                                 rsp_valid,
   input  logic                                 rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]           rsp_id,
   output logic [DIM*DIM*OUT_WIDTH-1:0]         rsp_y,
   output logic                                 rsp_timeout,
   output logic                                 busy
);

   localparam int MI_W  = DIM * DIM * WIDTH;
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIME_MAX + 1);

   state_t             r_state;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   r_id;
   logic [CNT_W-1:0]   r_cnt;

   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_idx;
   logic               w_any;
   logic [MI_W-1:0]    w_sel_a;
   logic [MI_W-1:0]    w_sel_b;

   mxu_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // The accept strobe is the only combinational output; it must never leak during reset.
   assign req_ready = (r_state == ST_IDLE && reset_n) ? w_grant : '0;

   // One-hot AND-OR mux of the winner's operands.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sel_a = w_sel_a | (req_a[i*MI_W +: MI_W] & {MI_W{w_grant[i]}});
         w_sel_b = w_sel_b | (req_b[i*MI_W +: MI_W] & {MI_W{w_grant[i]}});
      end
   end

   // Job FSM: grant, single-cycle issue, bounded wait, held response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_rr_ptr     <= '0;
         r_id         <= '0;
         r_cnt        <= '0;
         mxu_in0      <= '0;
         mxu_in1      <= '0;
         mxu_in_valid <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_y        <= '0;
         rsp_timeout  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  mxu_in0      <= w_sel_a;
                  mxu_in1      <= w_sel_b;
                  mxu_in_valid <= 1'b1;
                  r_id         <= w_idx;
                  r_rr_ptr     <= IDX_W'(rr_next(int'(w_idx), NUM_REQ));
                  busy         <= 1'b1;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mxu_in_valid <= 1'b0;
               r_cnt        <= '0;
               r_state      <= ST_WAIT;
            end
            ST_WAIT: begin
               // A finish landing on the expiry cycle still counts as a real result.
               if (mxu_finished) begin
                  rsp_y       <= mxu_out;
                  rsp_timeout <= 1'b0;
                  rsp_id      <= r_id;
                  rsp_valid   <= 1'b1;
                  r_state     <= ST_RESP;
               end else if (r_cnt == CNT_W'(TIME_MAX - 1)) begin
                  rsp_y       <= '0;
                  rsp_timeout <= 1'b1;
                  rsp_id      <= r_id;
                  rsp_valid   <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               mxu_in_valid <= 1'b0;
               rsp_valid    <= 1'b0;
               busy         <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mxu_arbiter.md
MXU_ARBITER -- requirements
Module: mxu_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DIM, 4, matrix dimension.
- WIDTH, 8, input element bits.
- OUT_WIDTH, 2*WIDTH+$clog2(DIM), result element bits.
- NUM_REQ, 4, requester count, 2..8.
- TIME_MAX, 1024, max cycles waiting for multiplier finished.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, per-requester job request.
- req_ready, out, NUM_REQ, per-requester job accept; one-hot or zero.
- req_a, in, NUM_REQ x DIM x DIM x WIDTH, A operand per requester.
- req_b, in, NUM_REQ x DIM x DIM x WIDTH, B operand per requester.
- mxu_in0, out, DIM x DIM x WIDTH, to multiplier in0.
- mxu_in1, out, DIM x DIM x WIDTH, to multiplier in1.
- mxu_in_valid, out, 1, to multiplier in_valid; single-cycle pulse.
- mxu_out, in, DIM x DIM x OUT_WIDTH, from multiplier out.
- mxu_finished, in, 1, from multiplier finished.
- rsp_valid, out, 1, result available.
- rsp_ready, in, 1, consumer accepts result.
- rsp_id, out, $clog2(NUM_REQ), requester owning result.
- rsp_y, out, DIM x DIM x OUT_WIDTH, result matrix.
- rsp_timeout, out, 1, result invalid: multiplier timed out.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 FSM states IDLE, ISSUE, WAIT, RESP; one job in flight at a time.
REQ-004 IDLE: if any req_valid, grant round-robin winner = first set bit at or after rr_ptr (wrapping); assert req_ready[winner] combinationally that cycle; capture req_a/req_b and id into registers; go to ISSUE.
REQ-005 Grant cycle: rr_ptr <= winner+1 mod NUM_REQ; no req_ready asserted outside IDLE.
REQ-006 ISSUE: mxu_in_valid=1 for exactly one cycle with captured operands on mxu_in0/mxu_in1; go to WAIT; operands held stable until RESP.
REQ-007 WAIT: timeout counter cleared on ISSUE, increments each WAIT cycle; on mxu_finished, capture mxu_out into rsp_y, rsp_timeout=0, go RESP; else if counter reaches TIME_MAX-1, rsp_y=0, rsp_timeout=1, go RESP.
REQ-008 mxu_finished in the same cycle as timeout expiry: finished wins (rsp_timeout=0).
REQ-009 mxu_finished outside WAIT ignored.
REQ-010 RESP: rsp_valid=1 with rsp_id, rsp_y, rsp_timeout stable until rsp_ready; on rsp_valid&&rsp_ready go IDLE.
REQ-011 Minimum latency grant-to-rsp_valid = 2 + multiplier latency cycles; back-to-back throughput limited by one IDLE cycle per job.
REQ-012 Requester deasserting req_valid before grant: no job, no side effect.
REQ-013 All outputs registered except req_ready.

Reset
REQ-014 reset_n low asynchronously forces: state IDLE, rr_ptr 0, counter 0, req_ready 0, mxu_in_valid 0, rsp_valid 0, rsp_id 0, rsp_y 0, rsp_timeout 0, busy 0, mxu_in0/mxu_in1 0.
REQ-015 Reset mid-job (any state) drops the job silently; a later mxu_finished from the aborted job is ignored while IDLE.

Structure
REQ-016 Shared package holds matrix_in_t, matrix_out_t typedefs and state enum; DIM/WIDTH defaults match tb_define.vh.
REQ-017 One sub-module: mxu_rr_arbiter (NUM_REQ request vector + pointer -> one-hot grant + index), combinational.

Verification
REQ-018 Single job: requester 2 sends A=identity, B=all-2; multiplier finishes after 5 cycles -> rsp_id=2, rsp_y=all-2, rsp_timeout=0, mxu_in_valid pulsed once.
REQ-019 Fairness: all four req_valid held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
REQ-020 Timeout: TIME_MAX=16, mxu_finished never asserted -> rsp_valid on 16th WAIT cycle, rsp_timeout=1, rsp_y=0.
REQ-021 Backpressure: rsp_ready low for 10 cycles -> rsp_* stable, no req_ready, no mxu_in_valid until handshake.
REQ-022 Reset in WAIT, then mxu_finished -> rsp_valid stays 0, state IDLE, rr_ptr 0.
REQ-023 Finished on same cycle as timeout expiry -> rsp_timeout=0, rsp_y=mxu_out.
